// File: rtl/stepper_pkg.sv
// Shared types and helpers for the multi-axis stepper pulse generator.
// No logic of its own: axis state encoding and the step-period clamp.
// Ports: none.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } axis_state_t;

  // A period shorter than two pulse widths cannot hold a full HIGH plus an
  // equally long LOW, so it is raised to that minimum.
  function automatic logic [31:0] clamp_period(input logic [31:0] period,
                                               input logic [31:0] min_per);
    return (period < min_per) ? min_per : period;
  endfunction

endpackage

// File: rtl/stepper_axis.sv
// One stepper axis: move-command FSM, per-axis timer and remaining-step counter.
// Latency: first STEP rise DIR_SETUP cycles after accept; rise-to-rise = clamped period.
// Backpressure: cmd_ready only in IDLE; a command offered while busy waits at the master.
// Ports: clock/reset_n, en (pause), cmd_* handshake + payload, abort,
//        step_out/dir_out pins, busy/done/aborted status, steps_left.
module stepper_axis
  import stepper_pkg::*;
#(
  parameter int STEP_W    = 16,
  parameter int PER_W     = 20,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [PER_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left
);

  // Timer must hold the larger of the fixed delays and any programmable period.
  localparam int FIX_MAX = (DIR_SETUP > 2 * PULSE_W) ? DIR_SETUP : 2 * PULSE_W;
  localparam int FIX_W   = $clog2(FIX_MAX + 1);
  localparam int CNT_W   = (FIX_W > PER_W) ? FIX_W : PER_W;

  axis_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              dir_q, dir_d;
  logic              hold_q, hold_d;     // abort seen during HIGH, acted on at pulse end
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Timers count down to zero; each phase loads length-1 so that a phase of
  // length L occupies exactly L cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_d = 1'b0;
        // abort is deliberately ignored here, even alongside cmd_valid
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          per_d   = CNT_W'(clamp_period(32'(cmd_period), 32'(2 * PULSE_W)));
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = CNT_W'(DIR_SETUP - 1);
          end
        end
      end
      SETUP: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (en) begin
          if (cnt_q == '0) begin
            state_d = HIGH;
            cnt_d   = CNT_W'(PULSE_W - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      HIGH: begin
        // Pulse runs to completion regardless of en or abort.
        if (abort) hold_d = 1'b1;
        if (cnt_q == '0) begin
          steps_d = steps_q - STEP_W'(1);
          if (abort || hold_q) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = per_q - CNT_W'(PULSE_W + 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        // Abort is checked first so it wins over a completion on the same edge.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (en) begin
          if (cnt_q == '0) begin
            if (steps_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = HIGH;
              cnt_d   = CNT_W'(PULSE_W - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign step_out   = (state_q == HIGH);
  assign dir_out    = dir_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_q;

endmodule

// File: rtl/multi_axis_stepper.sv
// N independent stepper axes behind per-axis valid/ready command ports.
// Latency: per axis, first STEP DIR_SETUP cycles after accept; no cross-axis coupling.
// Backpressure: each axis accepts only when idle; others are unaffected.
// Ports: vectors per axis (bit i / slice [i*W +: W]) for commands, abort, pins and status.
module multi_axis_stepper
  import stepper_pkg::*;
#(
  parameter int N_AXES    = 2,
  parameter int STEP_W    = 16,
  parameter int PER_W     = 20,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 20
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [N_AXES-1:0]        cmd_valid,
  output logic [N_AXES-1:0]        cmd_ready,
  input  logic [N_AXES-1:0]        cmd_dir,
  input  logic [N_AXES*STEP_W-1:0] cmd_steps,
  input  logic [N_AXES*PER_W-1:0]  cmd_period,
  input  logic [N_AXES-1:0]        abort,
  output logic [N_AXES-1:0]        step_out,
  output logic [N_AXES-1:0]        dir_out,
  output logic [N_AXES-1:0]        busy,
  output logic [N_AXES-1:0]        done,
  output logic [N_AXES-1:0]        aborted,
  output logic [N_AXES*STEP_W-1:0] steps_left
);

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    stepper_axis #(
      .STEP_W   (STEP_W),
      .PER_W    (PER_W),
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_axis (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en),
      .cmd_valid (cmd_valid[i]),
      .cmd_ready (cmd_ready[i]),
      .cmd_dir   (cmd_dir[i]),
      .cmd_steps (cmd_steps[i*STEP_W +: STEP_W]),
      .cmd_period(cmd_period[i*PER_W +: PER_W]),
      .abort     (abort[i]),
      .step_out  (step_out[i]),
      .dir_out   (dir_out[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .aborted   (aborted[i]),
      .steps_left(steps_left[i*STEP_W +: STEP_W])
    );
  end

endmodule

// File: tb/tb_multi_axis_stepper.sv
module tb_multi_axis_stepper;

  localparam int N     = 2;
  localparam int SW    = 16;
  localparam int PW_W  = 20;
  localparam int PULSE = 2;
  localparam int DS    = 3;

  logic            clock;
  logic            reset_n;
  logic            en;
  logic [N-1:0]    cmd_valid, cmd_ready, cmd_dir, abort;
  logic [N-1:0]    step_out, dir_out, busy, done, aborted;
  logic [N*SW-1:0] cmd_steps, steps_left;
  logic [N*PW_W-1:0] cmd_period;

  multi_axis_stepper #(
    .N_AXES(N), .STEP_W(SW), .PER_W(PW_W), .PULSE_W(PULSE), .DIR_SETUP(DS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int t; int kind; } ev_t;   // kind 1 = done, 2 = aborted
  int  rise_q0[$];
  int  rise_q1[$];
  ev_t end_q0[$];
  ev_t end_q1[$];
  int  rise_t[N];
  bit  prev_step[N];

  typedef struct {
    int axis; bit dir; int steps; int period; int exp_per; int done_off;
  } vec_t;
  vec_t tbl[5];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_rise(input int a, input int t);
    if (a == 0) rise_q0.push_back(t); else rise_q1.push_back(t);
  endfunction

  function automatic void push_end(input int a, input int t, input int k);
    ev_t e;
    e.t = t;
    e.kind = k;
    if (a == 0) end_q0.push_back(e); else end_q1.push_back(e);
  endfunction

  function automatic int pop_rise(input int a);
    int v = -1;
    if (a == 0) begin
      if (rise_q0.size() > 0) v = rise_q0.pop_front();
    end else begin
      if (rise_q1.size() > 0) v = rise_q1.pop_front();
    end
    return v;
  endfunction

  function automatic ev_t pop_end(input int a);
    ev_t e;
    e.t = -1;
    e.kind = 0;
    if (a == 0) begin
      if (end_q0.size() > 0) e = end_q0.pop_front();
    end else begin
      if (end_q1.size() > 0) e = end_q1.pop_front();
    end
    return e;
  endfunction

  function automatic int q_left(input int a);
    return (a == 0) ? (rise_q0.size() + end_q0.size()) : (rise_q1.size() + end_q1.size());
  endfunction

  // Output monitor: compares every STEP rise, pulse width and done/aborted
  // pulse against the expectations queued when the command was driven.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      for (int a = 0; a < N; a++) begin
        if (!reset_n) begin
          prev_step[a] = 1'b0;
        end else begin
          if (step_out[a] && !prev_step[a]) begin
            check($sformatf("rise_time_ax%0d", a), cyc, pop_rise(a));
            rise_t[a] = cyc;
          end
          if (!step_out[a] && prev_step[a])
            check($sformatf("pulse_width_ax%0d", a), cyc - rise_t[a], PULSE);
          prev_step[a] = step_out[a];
          if (done[a] || aborted[a]) begin
            e = pop_end(a);
            check($sformatf("done_and_aborted_ax%0d", a), done[a] & aborted[a], 0);
            check($sformatf("busy_at_end_ax%0d", a), busy[a], 0);
            check($sformatf("end_kind_ax%0d", a), done[a] ? 1 : 2, e.kind);
            check($sformatf("end_time_ax%0d", a), cyc, e.t);
          end
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Called at a negedge; the command is accepted on the following posedge (acc).
  task automatic send(input int a, input bit d, input int s, input int p,
                      input int exp_per, input int done_off, input bit std_exp,
                      input bit with_abort, output int acc);
    check($sformatf("cmd_ready_before_ax%0d", a), cmd_ready[a], 1);
    cmd_valid[a] = 1'b1;
    cmd_dir[a]   = d;
    cmd_steps[a*SW +: SW]     = SW'(s);
    cmd_period[a*PW_W +: PW_W] = PW_W'(p);
    if (with_abort) abort[a] = 1'b1;
    acc = cyc + 1;
    if (std_exp) begin
      for (int k = 0; k < s; k++) push_rise(a, acc + DS + k * exp_per);
      push_end(a, acc + done_off, 1);
    end
    @(negedge clock);
    cmd_valid[a] = 1'b0;
    abort[a]     = 1'b0;
  endtask

  initial begin
    int acc;
    reset_n = 1'b0;
    en = 1'b1;
    cmd_valid = '0; cmd_dir = '0; abort = '0;
    cmd_steps = '0; cmd_period = '0;

    tbl[0] = '{0, 1'b1, 3, 10, 10, 33};  // basic three-step move
    tbl[1] = '{0, 1'b0, 0, 5, 0, 0};     // zero steps: done only
    tbl[2] = '{0, 1'b1, 2, 1, 4, 11};    // period clamped to 2*PULSE
    tbl[3] = '{1, 1'b0, 4, 4, 4, 19};    // period exactly at the clamp
    tbl[4] = '{1, 1'b1, 1, 7, 7, 10};    // single step, odd period

    repeat (3) @(negedge clock);
    check("rst_step_out", step_out, 0);
    check("rst_dir_out", dir_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_steps_left", steps_left, 0);
    check("rst_cmd_ready", cmd_ready, 2'b11);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].axis, tbl[i].dir, tbl[i].steps, tbl[i].period,
           tbl[i].exp_per, tbl[i].done_off, 1'b1, 1'b0, acc);
      check($sformatf("v%0d_dir_out", i), dir_out[tbl[i].axis], tbl[i].dir);
      check($sformatf("v%0d_busy", i), busy[tbl[i].axis], tbl[i].steps != 0);
      check($sformatf("v%0d_cmd_ready", i), cmd_ready[tbl[i].axis], tbl[i].steps == 0);
      if (tbl[i].steps > 0) begin
        wait_until(acc + DS + PULSE);
        check($sformatf("v%0d_steps_left_after_first", i),
              steps_left[tbl[i].axis*SW +: SW], tbl[i].steps - 1);
      end
      wait_until(acc + tbl[i].done_off + 2);
      check($sformatf("v%0d_events_seen", i), q_left(tbl[i].axis), 0);
      check($sformatf("v%0d_steps_left_end", i), steps_left[tbl[i].axis*SW +: SW], 0);
      check($sformatf("v%0d_idle", i), busy[tbl[i].axis], 0);
    end

    // Pause for 7 cycles inside the first LOW, then a 1-cycle pause inside a HIGH.
    send(0, 1'b1, 3, 10, 0, 0, 1'b0, 1'b0, acc);
    push_rise(0, acc + 3); push_rise(0, acc + 20); push_rise(0, acc + 30);
    push_end(0, acc + 40, 1);
    wait_until(acc + 6);  en = 1'b0;
    wait_until(acc + 13); en = 1'b1;
    wait_until(acc + 30); en = 1'b0;
    wait_until(acc + 31); en = 1'b1;
    wait_until(acc + 42);
    check("pause_events_seen", q_left(0), 0);

    // Abort during the second HIGH: pulse completes, one step left.
    send(0, 1'b0, 3, 10, 0, 0, 1'b0, 1'b0, acc);
    push_rise(0, acc + 3); push_rise(0, acc + 13); push_end(0, acc + 15, 2);
    wait_until(acc + 13); abort[0] = 1'b1;
    wait_until(acc + 14); abort[0] = 1'b0;
    wait_until(acc + 17);
    check("abort_high_steps_left", steps_left[0 +: SW], 1);
    check("abort_high_events_seen", q_left(0), 0);

    // Abort in SETUP: no pulse at all.
    send(1, 1'b1, 2, 6, 0, 0, 1'b0, 1'b0, acc);
    push_end(1, acc + 1, 2);
    abort[1] = 1'b1;
    wait_until(acc + 1); abort[1] = 1'b0;
    wait_until(acc + 4);
    check("abort_setup_steps_left", steps_left[SW +: SW], 2);
    check("abort_setup_events_seen", q_left(1), 0);

    // Abort on the very edge the final LOW ends: aborted wins over done.
    send(1, 1'b0, 1, 4, 0, 0, 1'b0, 1'b0, acc);
    push_rise(1, acc + 3); push_end(1, acc + 7, 2);
    wait_until(acc + 6); abort[1] = 1'b1;
    wait_until(acc + 7); abort[1] = 1'b0;
    wait_until(acc + 9);
    check("abort_vs_done_events_seen", q_left(1), 0);

    // Abort while IDLE together with a command: the command still runs.
    send(0, 1'b1, 1, 4, 4, 7, 1'b1, 1'b1, acc);
    check("idle_abort_accepted", busy[0], 1);
    wait_until(acc + 9);
    check("idle_abort_events_seen", q_left(0), 0);

    // Both axes commanded on the same edge with different moves.
    cmd_valid = 2'b11; cmd_dir = 2'b10;
    cmd_steps = {16'd5, 16'd2}; cmd_period = {20'd9, 20'd6};
    acc = cyc + 1;
    push_rise(0, acc + 3); push_rise(0, acc + 9); push_end(0, acc + 15, 1);
    for (int k = 0; k < 5; k++) push_rise(1, acc + 3 + k * 9);
    push_end(1, acc + 48, 1);
    @(negedge clock);
    cmd_valid = '0;
    check("dual_dir_out", dir_out, 2'b10);
    check("dual_busy", busy, 2'b11);
    wait_until(acc + 20);
    check("dual_ax0_events_seen", q_left(0), 0);
    check("dual_ax1_still_busy", busy[1], 1);
    wait_until(acc + 50);
    check("dual_ax1_events_seen", q_left(1), 0);
    check("dual_steps_left", steps_left, 0);

    // Reset in the middle of a move: everything drops at once, no status pulse.
    cmd_valid = 2'b11; cmd_dir = 2'b11;
    cmd_steps = {16'd5, 16'd5}; cmd_period = {20'd10, 20'd10};
    acc = cyc + 1;
    push_rise(0, acc + 3); push_rise(1, acc + 3);
    @(negedge clock);
    cmd_valid = '0;
    wait_until(acc + 3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_step_out", step_out, 0);
    check("midrst_dir_out", dir_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_steps_left", steps_left, 0);
    check("midrst_cmd_ready", cmd_ready, 2'b11);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("midrst_ax0_events_seen", q_left(0), 0);
    check("midrst_ax1_events_seen", q_left(1), 0);
    check("midrst_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
